// File: rtl/filt_ppi_if.sv
// Sample-stream bundle between the low-rate source and the polyphase interpolator.
// The source drives the enable and input sample. The filter returns the output sample and the slow-rate strobe.
interface filt_ppi_if #(
  parameter int gp_idata_width = 8,
  parameter int gp_odata_width = 21
);
  logic                             i_ena;
  logic signed [gp_idata_width-1:0] i_data;
  logic signed [gp_odata_width-1:0] o_data;
  logic                             o_sclk;

  modport master (output i_ena, output i_data, input o_data, input o_sclk);
  modport slave  (input i_ena, input i_data, output o_data, output o_sclk);
endinterface

// File: rtl/filt_ppi.sv
// Polyphase interpolation FIR: one input per L enabled cycles, one output per enabled cycle.
// Each phase uses D taps, and the phase counter selects the coefficient set for those taps.
module filt_ppi #(
  parameter int gp_idata_width          = 8,
  parameter int gp_interpolation_factor = 4,
  parameter int gp_coeff_length         = 17,
  parameter int gp_coeff_width          = 8,
  parameter logic [gp_coeff_length*gp_coeff_width-1:0] gp_coeffs =
    136'h11100F0E0D0C0B0A090807060504030201,
  localparam int gp_taps_per_phase =
    (gp_coeff_length + gp_interpolation_factor - 1) / gp_interpolation_factor,
  localparam int gp_odata_width = gp_idata_width + gp_coeff_width + gp_taps_per_phase
) (
  input logic    i_clk,
  input logic    i_rst_an,
  filt_ppi_if.slave bus
);

  localparam int IW    = gp_idata_width;
  localparam int CW    = gp_coeff_width;
  localparam int PW    = IW + CW;
  localparam int OW    = gp_odata_width;
  localparam int L     = gp_interpolation_factor;
  localparam int N     = gp_coeff_length;
  localparam int D     = gp_taps_per_phase;
  localparam int CNT_W = (L > 1) ? $clog2(L) : 1;

  // Coefficients beyond N read as zero, which pads the filter to D*L taps.
  function automatic logic signed [CW-1:0] coef_at(input int k);
    logic signed [CW-1:0] c;
    if (k < N) begin
      c = gp_coeffs[k*CW +: CW];
    end else begin
      c = '0;
    end
    return c;
  endfunction

  logic [CNT_W-1:0]        cnt_r;
  logic [CNT_W-1:0]        cnt_nxt_s;
  logic                    sclk_r;
  logic signed [IW-1:0]    x_r    [D];
  logic signed [IW-1:0]    xs_s   [D];
  logic signed [CW-1:0]    coef_s [D];
  logic signed [PW-1:0]    prod_s [D];
  logic signed [OW-1:0]    acc_s;
  logic signed [OW-1:0]    o_data_r;

  // Phase counter successor; wraps after phase L-1.
  always_comb begin
    cnt_nxt_s = '0;
    if (cnt_r == CNT_W'(L - 1)) begin
      cnt_nxt_s = '0;
    end else begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end
  end

  // In phase 0 the MAC sees the delay line already shifted, so a new sample contributes in the same cycle.
  always_comb begin
    for (int m = 0; m < D; m++) begin
      xs_s[m] = x_r[m];
    end
    if (cnt_r == '0) begin
      xs_s[0] = bus.i_data;
      for (int m = 1; m < D; m++) begin
        xs_s[m] = x_r[m-1];
      end
    end else begin
      xs_s[0] = x_r[0];
    end
  end

  // One multiplier per tap. The coefficient mux on cnt selects h[cnt + m*L].
  always_comb begin
    acc_s = '0;
    for (int m = 0; m < D; m++) begin
      coef_s[m] = coef_at(int'(cnt_r) + m * L);
      prod_s[m] = PW'(xs_s[m]) * PW'(coef_s[m]);
      acc_s     = acc_s + {{(OW-PW){prod_s[m][PW-1]}}, prod_s[m]};
    end
  end

  // Phase, history and output state. All of it freezes while the enable is low.
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      cnt_r    <= '0;
      sclk_r   <= 1'b1;
      o_data_r <= '0;
      for (int m = 0; m < D; m++) begin
        x_r[m] <= '0;
      end
    end else if (bus.i_ena) begin
      cnt_r    <= cnt_nxt_s;
      sclk_r   <= (cnt_nxt_s == '0);
      o_data_r <= acc_s;
      x_r      <= xs_s;
    end
  end

  assign bus.o_data = o_data_r;
  assign bus.o_sclk = sclk_r;

endmodule
